// File: rtl/popcnt_rr_arbiter_if.sv
// rtl/popcnt_rr_arbiter_if.sv - requester, counter and response signals of the popcount arbiter
interface popcnt_rr_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int REQ_CNT = 4
);
    localparam int ID_W = $clog2(REQ_CNT);
    localparam int CW   = $clog2(WIDTH) + 1;

    logic [REQ_CNT*WIDTH-1:0] req_data_i;
    logic [REQ_CNT-1:0]       req_val_i;
    logic [REQ_CNT-1:0]       req_ready_o;
    logic [WIDTH-1:0]         cnt_data_o;
    logic                     cnt_data_val_o;
    logic [CW-1:0]            cnt_data_i;
    logic                     cnt_data_val_i;
    logic [CW-1:0]            resp_data_o;
    logic [ID_W-1:0]          resp_id_o;
    logic                     resp_val_o;
    logic                     tag_err_o;

    modport slave (
        input  req_data_i, req_val_i, cnt_data_i, cnt_data_val_i,
        output req_ready_o, cnt_data_o, cnt_data_val_o,
               resp_data_o, resp_id_o, resp_val_o, tag_err_o
    );

    modport master (
        output req_data_i, req_val_i, cnt_data_i, cnt_data_val_i,
        input  req_ready_o, cnt_data_o, cnt_data_val_o,
               resp_data_o, resp_id_o, resp_val_o, tag_err_o
    );
endinterface

// File: rtl/popcnt_rr_arbiter.sv
// rtl/popcnt_rr_arbiter.sv - round-robin sharing of one external popcount unit
// with a fixed-latency id tag pipeline that labels each returned result.
module popcnt_rr_arbiter #(
    parameter int WIDTH       = 8,
    parameter int REQ_CNT     = 4,
    parameter int CNT_LATENCY = 2
) (
    input  logic               clk,
    input  logic               srst_i,
    popcnt_rr_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(REQ_CNT);
    localparam int CW    = $clog2(WIDTH) + 1;
    localparam int DEPTH = CNT_LATENCY + 1;

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       winner;
    logic                  found;
    logic                  xfer;
    logic [REQ_CNT-1:0]    ready;
    logic [WIDTH-1:0]      win_word;
    logic [WIDTH-1:0]      cnt_data_q, cnt_data_d;
    logic                  cnt_val_q, cnt_val_d;
    logic [DEPTH-1:0]      tag_val_q, tag_val_d;
    logic [DEPTH*ID_W-1:0] tag_id_q, tag_id_d;
    logic                  last_val;
    logic [ID_W-1:0]       last_id;
    logic [CW-1:0]         resp_data_q, resp_data_d;
    logic [ID_W-1:0]       resp_id_q, resp_id_d;
    logic                  resp_val_q, resp_val_d;
    logic                  tag_err_q, tag_err_d;

    // Rotating search from the pointer; wrap is explicit so non-power-of-two counts work.
    always_comb begin
        logic [ID_W:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(REQ_CNT)) begin
                idx = idx - (ID_W+1)'(REQ_CNT);
            end
            if (!found && bus.req_val_i[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        xfer  = found && !srst_i;
        ready = '0;
        if (xfer) begin
            ready[winner] = 1'b1;
        end

        win_word = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            if (winner == ID_W'(k)) begin
                win_word = bus.req_data_i[k*WIDTH +: WIDTH];
            end
        end

        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (winner == ID_W'(REQ_CNT - 1)) ? '0 : winner + 1'b1;
        end

        cnt_data_d = xfer ? win_word : cnt_data_q;
        cnt_val_d  = xfer;

        // Stage 0 captures the tag on the same edge the word goes to the counter.
        tag_val_d = {tag_val_q[DEPTH-2:0], xfer};
        tag_id_d  = {tag_id_q[(DEPTH-1)*ID_W-1:0], winner};
        last_val  = tag_val_q[DEPTH-1];
        last_id   = tag_id_q[DEPTH*ID_W-1 -: ID_W];

        resp_val_d  = bus.cnt_data_val_i;
        resp_data_d = bus.cnt_data_val_i ? bus.cnt_data_i : resp_data_q;
        resp_id_d   = bus.cnt_data_val_i ? last_id : resp_id_q;
        tag_err_d   = tag_err_q | (bus.cnt_data_val_i != last_val);
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            ptr_q       <= '0;
            cnt_data_q  <= '0;
            cnt_val_q   <= 1'b0;
            tag_val_q   <= '0;
            tag_id_q    <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            resp_val_q  <= 1'b0;
            tag_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_data_q  <= cnt_data_d;
            cnt_val_q   <= cnt_val_d;
            tag_val_q   <= tag_val_d;
            tag_id_q    <= tag_id_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            resp_val_q  <= resp_val_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign bus.req_ready_o    = ready;
    assign bus.cnt_data_o     = cnt_data_q;
    assign bus.cnt_data_val_o = cnt_val_q;
    assign bus.resp_data_o    = resp_data_q;
    assign bus.resp_id_o      = resp_id_q;
    assign bus.resp_val_o     = resp_val_q;
    assign bus.tag_err_o      = tag_err_q;
endmodule

// File: tb/tb_popcnt_rr_arbiter.sv
// tb/tb_popcnt_rr_arbiter.sv - directed bench for popcnt_rr_arbiter with a two-cycle counter model
module tb_popcnt_rr_arbiter;
    localparam int WIDTH       = 8;
    localparam int REQ_CNT     = 4;
    localparam int CNT_LATENCY = 2;

    logic clk = 1'b0;
    logic srst;
    logic inject;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int acc_id[$];
    int acc_cyc[$];
    int rsp_id[$];
    int rsp_dat[$];
    int rsp_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    popcnt_rr_arbiter_if #(.WIDTH(WIDTH), .REQ_CNT(REQ_CNT)) bus ();

    popcnt_rr_arbiter #(
        .WIDTH(WIDTH),
        .REQ_CNT(REQ_CNT),
        .CNT_LATENCY(CNT_LATENCY)
    ) dut (
        .clk(clk),
        .srst_i(srst),
        .bus(bus)
    );

    // Popcount unit: two register stages, reset together with the arbiter.
    logic       m_v0, m_v1;
    logic [3:0] m_d0, m_d1;
    always @(posedge clk) begin
        if (srst) begin
            m_v0 <= 1'b0;
            m_v1 <= 1'b0;
            m_d0 <= '0;
            m_d1 <= '0;
        end else begin
            m_v0 <= bus.cnt_data_val_o;
            m_d0 <= 4'($countones(bus.cnt_data_o));
            m_v1 <= m_v0;
            m_d1 <= m_d0;
        end
    end
    assign bus.cnt_data_val_i = m_v1 | inject;
    assign bus.cnt_data_i     = m_d1;

    always @(negedge clk) begin
        #2;
        for (int k = 0; k < REQ_CNT; k++) begin
            if (bus.req_val_i[k] && bus.req_ready_o[k]) begin
                acc_id.push_back(k);
                acc_cyc.push_back(cyc);
            end
        end
        if (bus.resp_val_o) begin
            rsp_id.push_back(int'(bus.resp_id_o));
            rsp_dat.push_back(int'(bus.resp_data_o));
            rsp_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        acc_id.delete();
        acc_cyc.delete();
        rsp_id.delete();
        rsp_dat.delete();
        rsp_cyc.delete();
    endtask

    task automatic check_resps(input string tag, input int ids[4], input int dats[4], input int n);
        check({tag, "_count"}, rsp_id.size(), n);
        for (int i = 0; i < n && i < rsp_id.size(); i++) begin
            check({tag, "_id"}, rsp_id[i], ids[i]);
            check({tag, "_data"}, rsp_dat[i], dats[i]);
        end
    endtask

    int full_dat[4]  = '{8, 4, 2, 1};
    int sp_ids[4]    = '{1, 3, 1, 3};
    int sp_dat[4]    = '{2, 3, 2, 3};
    int bd_ids[4]    = '{2, 2, 0, 0};
    int bd_dat[4]    = '{0, 8, 0, 0};
    int sp_grant[3]  = '{8, 2, 8};

    initial begin
        srst           = 1'b1;
        inject         = 1'b0;
        bus.req_val_i  = '1;
        bus.req_data_i = {8'h01, 8'h03, 8'h0F, 8'hFF};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_ready", int'(bus.req_ready_o), 0);
            check("rst_resp_val", int'(bus.resp_val_o), 0);
            check("rst_tag_err", int'(bus.tag_err_o), 0);
        end
        check("rst_cnt_val", int'(bus.cnt_data_val_o), 0);
        check("rst_cnt_data", int'(bus.cnt_data_o), 0);
        check("rst_resp_data", int'(bus.resp_data_o), 0);
        check("rst_resp_id", int'(bus.resp_id_o), 0);

        // Full contention: every requester valid for eight cycles.
        @(negedge clk);
        clear_logs();
        srst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("full_grant", int'(bus.req_ready_o), 1 << (i % 4));
            @(negedge clk);
        end
        bus.req_val_i = '0;
        repeat (8) @(negedge clk);
        check("full_acc_count", acc_id.size(), 8);
        check("full_resp_count", rsp_id.size(), 8);
        for (int i = 0; i < 8 && i < rsp_id.size(); i++) begin
            check("full_resp_id", rsp_id[i], i % 4);
            check("full_resp_data", rsp_dat[i], full_dat[i % 4]);
        end
        check("full_latency", (rsp_cyc.size() > 0 && acc_cyc.size() > 0) ? rsp_cyc[0] - acc_cyc[0] : -1, 4);
        check("full_throughput", (rsp_cyc.size() == 8) ? rsp_cyc[7] - rsp_cyc[0] : -1, 7);

        // Sparse: one transfer from 1 moves the pointer to 2, then only 1 and 3 request.
        clear_logs();
        bus.req_data_i = {8'h07, 8'h00, 8'h03, 8'h00};
        bus.req_val_i  = 4'b0010;
        #1;
        check("sparse_setup", int'(bus.req_ready_o), 2);
        @(negedge clk);
        bus.req_val_i = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sparse_grant", int'(bus.req_ready_o), sp_grant[i]);
            @(negedge clk);
        end
        bus.req_val_i = '0;
        repeat (8) @(negedge clk);
        check_resps("sparse", sp_ids, sp_dat, 4);

        // Boundary data words from requester 2.
        clear_logs();
        bus.req_data_i = '0;
        bus.req_val_i  = 4'b0100;
        #1;
        check("bound_grant0", int'(bus.req_ready_o), 4);
        @(negedge clk);
        bus.req_data_i[23:16] = 8'hFF;
        #1;
        check("bound_grant1", int'(bus.req_ready_o), 4);
        @(negedge clk);
        bus.req_val_i = '0;
        repeat (8) @(negedge clk);
        check_resps("bound", bd_ids, bd_dat, 2);

        // Spurious counter result with nothing outstanding.
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        check("tagerr_set", int'(bus.tag_err_o), 1);
        check("tagerr_forward", int'(bus.resp_val_o), 1);
        repeat (4) @(negedge clk);
        #1;
        check("tagerr_sticky", int'(bus.tag_err_o), 1);
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        #1;
        check("tagerr_cleared", int'(bus.tag_err_o), 0);

        // Reset while two words are in flight.
        @(negedge clk);
        srst          = 1'b0;
        bus.req_val_i = 4'b0011;
        #1;
        check("mid_grant0", int'(bus.req_ready_o), 1);
        @(negedge clk);
        #1;
        check("mid_grant1", int'(bus.req_ready_o), 2);
        @(negedge clk);
        clear_logs();
        srst          = 1'b1;
        bus.req_val_i = '0;
        repeat (2) @(negedge clk);
        srst          = 1'b0;
        bus.req_val_i = '1;
        #1;
        check("mid_ptr_reset", int'(bus.req_ready_o), 1);
        bus.req_val_i = '0;
        repeat (8) @(negedge clk);
        #1;
        check("mid_no_resp", rsp_id.size(), 0);
        check("mid_tag_err", int'(bus.tag_err_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
